// File: rtl/nv_fifo_rwsthp_80x15_pkg.sv
// rtl/nv_fifo_rwsthp_80x15_pkg.sv - shared constants and pointer helper for the 80x15 FIFO and its RAM
package nv_fifo_rwsthp_80x15_pkg;

   localparam int DEPTH = 80;
   localparam int WIDTH = 15;
   localparam int PTR_W = 7;
   localparam int CNT_W = 7;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/nv_ram_rwsthp_80x15.sv
// rtl/nv_ram_rwsthp_80x15.sv - 80x15 RAM with latched read address, output register and bypass mux
module nv_ram_rwsthp_80x15
   import nv_fifo_rwsthp_80x15_pkg::*;
(
   input  logic             clk,
   input  logic [31:0]      pwrbus_ram_pd,
   input  logic [PTR_W-1:0] ra,
   input  logic             re,
   input  logic [PTR_W-1:0] wa,
   input  logic             we,
   input  logic [WIDTH-1:0] di,
   input  logic             byp_sel,
   input  logic [WIDTH-1:0] dbyp,
   input  logic             ore,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ra_d_q, ra_d_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             unused_pwrbus;

   assign unused_pwrbus = ^pwrbus_ram_pd;

   always_comb begin
      ra_d_d = re ? ra : ra_d_q;
      dout_d = dout_q;
      if (ore) begin
         dout_d = byp_sel ? dbyp : mem_q[ra_d_q];
      end
   end

   // Storage has no reset; the FIFO control never reads a slot it has not written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= di;
      end
      ra_d_q <= ra_d_d;
      dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule

// File: rtl/nv_fifo_rwsthp_80x15.sv
// rtl/nv_fifo_rwsthp_80x15.sv - 80+1 entry valid/ready FIFO sequencing a two-stage-read RAM with bypass
module nv_fifo_rwsthp_80x15
   import nv_fifo_rwsthp_80x15_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic [CNT_W-1:0] fifo_cnt,
   input  logic [31:0]      pwrbus_ram_pd
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
   logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic             s1_vld_q, s1_vld_d;
   logic             s2_vld_q, s2_vld_d;

   logic             s2_free, wr_acc, byp, ore, ore_ram, we, re, pop;
   logic [PTR_W-1:0] wa;

   always_comb begin
      s2_free = !s2_vld_q || rd_prdy;
      wr_prdy = !rst && (ram_cnt_q != CNT_W'(DEPTH));
      wr_acc  = wr_pvld && wr_prdy;
      byp     = wr_acc && (ram_cnt_q == '0) && !s1_vld_q && s2_free;
      ore     = !rst && (s1_vld_q || byp) && s2_free;
      ore_ram = ore && s1_vld_q;
      we      = wr_acc && !byp;
      wa      = wr_ptr_q;
      // A word written this cycle only becomes fetchable once unf_cnt_q counts it.
      re      = !rst && (unf_cnt_q != '0) && (!s1_vld_q || ore);
      pop     = s2_vld_q && rd_prdy;
   end

   always_comb begin
      wr_ptr_d   = we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      ram_cnt_d  = ram_cnt_q + CNT_W'(we) - CNT_W'(ore_ram);
      unf_cnt_d  = unf_cnt_q + CNT_W'(we) - CNT_W'(re);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_acc) - CNT_W'(pop);
      s1_vld_d   = re ? 1'b1 : (ore_ram ? 1'b0 : s1_vld_q);
      s2_vld_d   = ore ? 1'b1 : (rd_prdy ? 1'b0 : s2_vld_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         unf_cnt_q  <= '0;
         fifo_cnt_q <= '0;
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         unf_cnt_q  <= unf_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         s1_vld_q   <= s1_vld_d;
         s2_vld_q   <= s2_vld_d;
      end
   end

   nv_ram_rwsthp_80x15 u_ram (
      .clk           (clk),
      .pwrbus_ram_pd (pwrbus_ram_pd),
      .ra            (rd_ptr_q),
      .re            (re),
      .wa            (wa),
      .we            (we),
      .di            (wr_pd),
      .byp_sel       (byp),
      .dbyp          (wr_pd),
      .ore           (ore),
      .dout          (rd_pd)
   );

   assign rd_pvld  = s2_vld_q;
   assign fifo_cnt = fifo_cnt_q;

   a_cnt_max : assert property (@(posedge clk) disable iff (rst) fifo_cnt_q <= CNT_W'(DEPTH + 1));
   a_no_ovf  : assert property (@(posedge clk) disable iff (rst) !(wr_acc && (fifo_cnt_q == CNT_W'(DEPTH + 1))));
   a_no_unf  : assert property (@(posedge clk) disable iff (rst) !(pop && (fifo_cnt_q == '0)));

endmodule

// File: tb/tb_nv_fifo_rwsthp_80x15.sv
// tb/tb_nv_fifo_rwsthp_80x15.sv - self-checking bench for nv_fifo_rwsthp_80x15 against a queue model
module tb_nv_fifo_rwsthp_80x15;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
   logic [14:0] wr_pd, rd_pd;
   logic [6:0]  fifo_cnt;
   logic [31:0] pwrbus_ram_pd;

   int n_checks = 0;
   int n_fail   = 0;

   logic [14:0] model_q[$];

   typedef struct packed {
      logic        acc;
      logic        pop;
      logic [14:0] pd;
      logic [14:0] exp;
      logic        byp;
      logic        we;
      logic        clash;
   } obs_t;

   always #5 clk = ~clk;

   nv_fifo_rwsthp_80x15 dut (
      .clk           (clk),
      .rst           (rst),
      .wr_pvld       (wr_pvld),
      .wr_prdy       (wr_prdy),
      .wr_pd         (wr_pd),
      .rd_pvld       (rd_pvld),
      .rd_prdy       (rd_prdy),
      .rd_pd         (rd_pd),
      .fifo_cnt      (fifo_cnt),
      .pwrbus_ram_pd (pwrbus_ram_pd)
   );

   // Observe one cycle at the falling edge, then advance the queue model at the rising edge.
   task automatic tick(output obs_t o);
      @(negedge clk);
      o.acc   = wr_pvld && wr_prdy;
      o.pop   = rd_pvld && rd_prdy;
      o.pd    = rd_pd;
      o.exp   = 'x;
      if (o.pop && model_q.size() > 0) o.exp = model_q[0];
      o.byp   = dut.byp;
      o.we    = dut.we;
      o.clash = dut.we && dut.s1_vld_q && (dut.wa == dut.u_ram.ra_d_q);
      @(posedge clk);
      if (o.pop && model_q.size() > 0) void'(model_q.pop_front());
      if (o.acc) model_q.push_back(wr_pd);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld got %0b want 0", rd_pvld); end
      n_checks++; if (fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
      n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_prdy got %0b want 0", wr_prdy); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_prdy got %0b want 1", wr_prdy); end
      @(posedge clk); #1;
   endtask

   task automatic test_bypass();
      obs_t o;
      logic we_seen;
      wr_pd = 15'h1A5; wr_pvld = 1'b1; rd_prdy = 1'b1;
      tick(o);
      we_seen = o.we;
      n_checks++; if (o.acc !== 1'b1) begin n_fail++; $display("FAIL byp_acc got %0b want 1", o.acc); end
      n_checks++; if (o.byp !== 1'b1) begin n_fail++; $display("FAIL byp_taken got %0b want 1", o.byp); end
      wr_pvld = 1'b0;
      n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 15'h1A5) begin n_fail++; $display("FAIL byp_data got vld=%0b pd=%0h want vld=1 pd=1a5", rd_pvld, rd_pd); end
      n_checks++; if (fifo_cnt !== 7'd1) begin n_fail++; $display("FAIL byp_cnt1 got %0d want 1", fifo_cnt); end
      tick(o);
      we_seen = we_seen | o.we;
      n_checks++; if (o.pop !== 1'b1 || o.pd !== o.exp) begin n_fail++; $display("FAIL byp_pop got pop=%0b pd=%0h want pop=1 pd=%0h", o.pop, o.pd, o.exp); end
      n_checks++; if (fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL byp_cnt0 got %0d want 0", fifo_cnt); end
      n_checks++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL byp_no_we got %0b want 0", we_seen); end
   endtask

   task automatic test_fill();
      obs_t o;
      int nxt = 0, cyc = 0, got = 0;
      rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = '0;
      while (nxt < 81 && cyc < 300) begin
         tick(o); cyc++;
         if (o.acc) begin nxt++; wr_pd = 15'(nxt); end
      end
      n_checks++; if (nxt != 81 || cyc != 81) begin n_fail++; $display("FAIL fill_accept got %0d words in %0d cycles want 81 in 81", nxt, cyc); end
      n_checks++; if (fifo_cnt !== 7'd81) begin n_fail++; $display("FAIL fill_cnt got %0d want 81", fifo_cnt); end
      n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL fill_wr_prdy got %0b want 0", wr_prdy); end
      repeat (2) begin
         tick(o);
         n_checks++; if (o.acc !== 1'b0) begin n_fail++; $display("FAIL fill_refuse got acc=%0b want 0", o.acc); end
      end
      wr_pvld = 1'b0; rd_prdy = 1'b1; cyc = 0;
      while (got < 81 && cyc < 400) begin
         tick(o); cyc++;
         if (o.pop) begin
            n_checks++;
            if (o.pd !== o.exp || o.pd !== 15'(got)) begin n_fail++; $display("FAIL fill_drain got %0h want %0h", o.pd, got); end
            got++;
         end
      end
      n_checks++; if (got != 81 || fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL fill_drain_done got %0d words cnt=%0d want 81 cnt=0", got, fifo_cnt); end
      rd_prdy = 1'b0;
   endtask

   task automatic test_stream();
      obs_t o;
      int sent = 0, got = 0, cyc = 0;
      wr_pd = 15'($urandom);
      while (got < 1000 && cyc < 20000) begin
         wr_pvld = (sent < 1000) && ($urandom_range(0, 3) != 0);
         rd_prdy = 1'($urandom_range(0, 1));
         tick(o); cyc++;
         if (o.acc) begin sent++; wr_pd = 15'($urandom); end
         if (o.pop) begin
            n_checks++;
            if (o.pd !== o.exp) begin n_fail++; $display("FAIL stream_data word %0d got %0h want %0h", got, o.pd, o.exp); end
            got++;
         end
         n_checks++;
         if (fifo_cnt > 7'd81 || int'(fifo_cnt) != model_q.size()) begin n_fail++; $display("FAIL stream_cnt got %0d want %0d", fifo_cnt, model_q.size()); end
         n_checks++;
         if (o.clash !== 1'b0) begin n_fail++; $display("FAIL stream_slot_clash got %0b want 0", o.clash); end
      end
      n_checks++; if (got != 1000) begin n_fail++; $display("FAIL stream_done got %0d want 1000", got); end
      wr_pvld = 1'b0; rd_prdy = 1'b0;
   endtask

   task automatic test_full_simul();
      obs_t o;
      int cyc = 0, got = 0;
      logic [14:0] prev;
      rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 15'h100;
      while (model_q.size() < 81 && cyc < 300) begin
         tick(o); cyc++;
         if (o.acc) wr_pd = wr_pd + 15'd1;
      end
      n_checks++; if (fifo_cnt !== 7'd81) begin n_fail++; $display("FAIL full_cnt got %0d want 81", fifo_cnt); end
      rd_prdy = 1'b1;
      tick(o);
      n_checks++; if (o.acc !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_push got %0b want 0", o.acc); end
      n_checks++; if (o.pop !== 1'b1 || o.pd !== o.exp) begin n_fail++; $display("FAIL full_pop got pop=%0b pd=%0h want pop=1 pd=%0h", o.pop, o.pd, o.exp); end
      rd_prdy = 1'b0;
      tick(o);
      n_checks++; if (o.acc !== 1'b1) begin n_fail++; $display("FAIL full_next_push got %0b want 1", o.acc); end
      wr_pvld = 1'b0; rd_prdy = 1'b1; cyc = 0; prev = 15'h100;
      while (model_q.size() > 0 && cyc < 400) begin
         tick(o); cyc++;
         if (o.pop) begin
            n_checks++;
            if (o.pd !== o.exp || o.pd !== prev + 15'd1) begin n_fail++; $display("FAIL full_drain got %0h want %0h", o.pd, prev + 15'd1); end
            prev = o.pd; got++;
         end
      end
      n_checks++; if (got != 81 || fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL full_drain_done got %0d cnt=%0d want 81 cnt=0", got, fifo_cnt); end
      rd_prdy = 1'b0;
   endtask

   task automatic test_stall();
      obs_t o;
      logic [14:0] held;
      rd_prdy = 1'b0; wr_pvld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_pd = 15'(16'h200 + i);
         tick(o);
      end
      wr_pvld = 1'b0;
      repeat (3) tick(o);
      n_checks++; if (dut.s1_vld_q !== 1'b1 || rd_pvld !== 1'b1) begin n_fail++; $display("FAIL stall_primed got s1=%0b vld=%0b want 1 1", dut.s1_vld_q, rd_pvld); end
      held = rd_pd;
      n_checks++; if (held !== model_q[0]) begin n_fail++; $display("FAIL stall_head got %0h want %0h", held, model_q[0]); end
      for (int i = 0; i < 10; i++) begin
         tick(o);
         n_checks++; if (rd_pd !== held || rd_pvld !== 1'b1) begin n_fail++; $display("FAIL stall_hold cycle %0d got %0h want %0h", i, rd_pd, held); end
      end
      rd_prdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(o);
         n_checks++; if (o.pop !== 1'b1 || o.pd !== o.exp) begin n_fail++; $display("FAIL stall_release pop %0d got pop=%0b pd=%0h want pop=1 pd=%0h", i, o.pop, o.pd, o.exp); end
      end
      n_checks++; if (fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL stall_cnt got %0d want 0", fifo_cnt); end
      rd_prdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int cyc = 0;
      rd_prdy = 1'b0; wr_pvld = 1'b1;
      while (model_q.size() < 40 && cyc < 100) begin
         wr_pd = 15'($urandom);
         tick(o); cyc++;
      end
      wr_pvld = 1'b0;
      n_checks++; if (fifo_cnt !== 7'd40) begin n_fail++; $display("FAIL rmid_cnt40 got %0d want 40", fifo_cnt); end
      rst = 1'b1;
      model_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_prdy got %0b want 0", wr_prdy); end
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (rd_pvld !== 1'b0 || fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL rmid_cleared got vld=%0b cnt=%0d want 0 0", rd_pvld, fifo_cnt); end
      wr_pd = 15'h7FF; wr_pvld = 1'b1; rd_prdy = 1'b1;
      tick(o);
      n_checks++; if (o.acc !== 1'b1 || o.byp !== 1'b1) begin n_fail++; $display("FAIL rmid_byp got acc=%0b byp=%0b want 1 1", o.acc, o.byp); end
      wr_pvld = 1'b0;
      n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 15'h7FF) begin n_fail++; $display("FAIL rmid_data got vld=%0b pd=%0h want 1 7ff", rd_pvld, rd_pd); end
      tick(o);
      n_checks++; if (o.pop !== 1'b1 || o.pd !== o.exp || fifo_cnt !== 7'd0) begin n_fail++; $display("FAIL rmid_pop got pop=%0b pd=%0h cnt=%0d want 1 %0h 0", o.pop, o.pd, fifo_cnt, o.exp); end
   endtask

   initial begin
      pwrbus_ram_pd = 32'h0;
      test_reset();
      test_bypass();
      test_fill();
      test_stream();
      test_full_simul();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
